// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencing controller: fetches {op, A, B, C} from ROM and drives a synchronous data memory.
// Optional macro SUBLEQ_HALT_EN makes opcode 111 a sticky halt; without it every unknown opcode runs as SUBLEQ.
module subleq_ctrl #(
    parameter int P_ADDR = 8,
    parameter int P_DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [P_ADDR-1:0]     rom_addr,
    input  logic [3+3*P_ADDR-1:0] rom_data,
    output logic [P_ADDR-1:0]     mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [P_DATA-1:0]     mem_wdata,
    input  logic [P_DATA-1:0]     mem_rdata,
    input  logic [P_DATA-1:0]     inp_data,
    input  logic                  inp_valid,
    output logic                  inp_ready,
    output logic [P_DATA-1:0]     oup_data,
    output logic                  oup_valid,
    input  logic                  oup_ready,
    output logic                  halted
);

    // state   | meaning
    // FETCH   | register instruction word at PC
    // RDA     | read strobe for mem[A]
    // RDB     | read strobe for mem[B], capture mem[A]
    // EXEC    | write mem[A] with difference, branch or step PC
    // INWAIT  | wait for input word, store to mem[A], PC = C
    // OUTWAIT | present mem[A] on output until accepted, PC = C
    // HALT    | stopped until reset (SUBLEQ_HALT_EN only)
    typedef enum logic [2:0] {
        S_FETCH,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_INWAIT,
`ifdef SUBLEQ_HALT_EN
        S_OUTWAIT,
        S_HALT
`else
        S_OUTWAIT
`endif
    } state_t;

    typedef enum logic [2:0] {
        K_SUB,
        K_IMM,
        K_EXR,
        K_EXW,
        K_HALT
    } kind_t;

    localparam int IW = 3 + 3 * P_ADDR;

    function automatic kind_t decode(input logic [2:0] op);
        case (op)
            3'b100:  return K_IMM;
            3'b001:  return K_EXR;
            3'b010:  return K_EXW;
`ifdef SUBLEQ_HALT_EN
            3'b111:  return K_HALT;
`endif
            default: return K_SUB;
        endcase
    endfunction

    state_t            state, state_nxt;
    logic [P_ADDR-1:0] pc, pc_nxt;
    logic [IW-1:0]     ir;
    logic [P_DATA-1:0] a_val;
    logic [P_DATA-1:0] oup_q;
    logic              ow_hold;

    logic [P_ADDR-1:0] ir_a, ir_b, ir_c;
    kind_t             kind, fetch_kind;
    logic [P_DATA-1:0] imm_b, minuend, subtrahend, diff;
    logic              take;

    assign ir_a       = ir[3*P_ADDR-1 -: P_ADDR];
    assign ir_b       = ir[2*P_ADDR-1 -: P_ADDR];
    assign ir_c       = ir[P_ADDR-1:0];
    assign kind       = decode(ir[IW-1 -: 3]);
    assign fetch_kind = decode(rom_data[IW-1 -: 3]);

    // IMM reads only A, so mem[A] arrives in EXEC; SUBLEQ has mem[A] latched and mem[B] arriving.
    assign imm_b      = P_DATA'($signed(ir_b));
    assign minuend    = (kind == K_IMM) ? mem_rdata : a_val;
    assign subtrahend = (kind == K_IMM) ? imm_b : mem_rdata;
    assign diff       = minuend - subtrahend;
    assign take       = diff[P_DATA-1] | (diff == '0);

    assign rom_addr  = pc;
    assign inp_ready = (state == S_INWAIT);
    assign oup_valid = (state == S_OUTWAIT);
    // First OUTWAIT cycle forwards the read data; later cycles replay the held copy.
    assign oup_data  = ((state == S_OUTWAIT) && !ow_hold) ? mem_rdata : oup_q;

`ifdef SUBLEQ_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_FETCH: begin
                case (fetch_kind)
                    K_EXR:   state_nxt = S_INWAIT;
`ifdef SUBLEQ_HALT_EN
                    K_HALT:  state_nxt = S_HALT;
`endif
                    default: state_nxt = S_RDA;
                endcase
            end
            S_RDA: begin
                mem_re   = 1'b1;
                mem_addr = ir_a;
                case (kind)
                    K_IMM:   state_nxt = S_EXEC;
                    K_EXW:   state_nxt = S_OUTWAIT;
                    default: state_nxt = S_RDB;
                endcase
            end
            S_RDB: begin
                mem_re    = 1'b1;
                mem_addr  = ir_b;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                mem_we    = 1'b1;
                mem_addr  = ir_a;
                mem_wdata = diff;
                pc_nxt    = take ? ir_c : pc + P_ADDR'(1);
                state_nxt = S_FETCH;
            end
            S_INWAIT: begin
                if (inp_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = ir_a;
                    mem_wdata = inp_data;
                    pc_nxt    = ir_c;
                    state_nxt = S_FETCH;
                end
            end
            S_OUTWAIT: begin
                if (oup_ready) begin
                    pc_nxt    = ir_c;
                    state_nxt = S_FETCH;
                end
            end
`ifdef SUBLEQ_HALT_EN
            S_HALT: state_nxt = S_HALT;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            a_val   <= '0;
            oup_q   <= '0;
            ow_hold <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ow_hold <= (state == S_OUTWAIT) && !oup_ready;
            if (state == S_FETCH)
                ir <= rom_data;
            if (state == S_RDB)
                a_val <= mem_rdata;
            if (state == S_OUTWAIT)
                oup_q <= oup_data;
        end
    end

endmodule

// File: doc/subleq_ctrl.md
SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

Interface
REQ-001 SHALL have parameter P_ADDR, default 8, meaning the width of the ROM address, data-memory address and each operand field.
REQ-002 SHALL have parameter P_DATA, default 8, meaning the data-memory word width in two's complement.
REQ-003 SHALL have ports, one per line, as follows:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  rom_addr  out  P_ADDR  program counter (PC), drives the instruction ROM address
  rom_data  in  3+3*P_ADDR  instruction, combinational from ROM, laid out as {op[2:0], A, B, C}
  mem_addr  out  P_ADDR  data-memory address
  mem_re  out  1  data-memory read strobe; mem_rdata is valid in the cycle after the strobe
  mem_we  out  1  data-memory write strobe
  mem_wdata  out  P_DATA  data-memory write data
  mem_rdata  in  P_DATA  data-memory read data
  inp_data  in  P_DATA  external input word
  inp_valid  in  1  external input word available
  inp_ready  out  1  controller accepting input
  oup_data  out  P_DATA  external output word
  oup_valid  out  1  output word available
  oup_ready  in  1  sink accepting output
  halted  out  1  controller stopped

Function
REQ-004 SHALL decode op as: 000 SUBLEQ, 100 IMM, 001 EXR, 010 EXW; every other opcode SHALL be handled per REQ-016.
REQ-005 SHALL step through the states FETCH, RDA, RDB, EXEC, INWAIT, OUTWAIT and HALT, and SHALL register the instruction word in FETCH.
REQ-006 SUBLEQ SHALL run the sequence FETCH->RDA->RDB->EXEC->FETCH, taking exactly 4 cycles, and SHALL write mem[A] = mem[A] - mem[B].
REQ-007 IMM SHALL run the sequence FETCH->RDA->EXEC->FETCH, taking exactly 3 cycles, and SHALL write mem[A] = mem[A] - sext(B) with no read of B.
REQ-008 The subtraction result SHALL wrap modulo 2^P_DATA.
REQ-009 The branch SHALL be taken, setting PC = C, when the result has MSB = 1 or equals 0; otherwise PC = PC+1, wrapping modulo 2^P_ADDR.
REQ-010 In EXEC, mem_we SHALL be high for exactly one cycle, with mem_addr = A, and PC SHALL update on the same edge.
REQ-011 EXR SHALL run the sequence FETCH->INWAIT; inp_ready SHALL be high only while in INWAIT.
REQ-012 In INWAIT, on an edge where inp_valid & inp_ready, the controller SHALL write mem[A] = inp_data (mem_we asserted that cycle), set PC = C unconditionally, and return to FETCH.
REQ-013 EXW SHALL run the sequence FETCH->RDA->OUTWAIT.
REQ-014 On entering OUTWAIT, oup_data SHALL be loaded with mem[A], and oup_valid SHALL go high with oup_data held stable until an edge with oup_ready = 1; on that edge PC = C and the state returns to FETCH, and oup_valid SHALL be low the next cycle.
REQ-015 If oup_ready is already high on entry to OUTWAIT, the transfer SHALL complete in one cycle; the same SHALL hold for inp_valid in INWAIT.
REQ-016 Handling of opcodes other than those in REQ-004 SHALL depend on SUBLEQ_HALT_EN as defined under Configuration.
REQ-017 Outside EXEC and the INWAIT handshake cycle, mem_we SHALL be 0; mem_re SHALL be 1 only in RDA and RDB.
REQ-018 A branch target C equal to the current PC SHALL be legal and SHALL loop without halting.

Reset
REQ-019 While rst_n = 0, the controller SHALL immediately set state FETCH, PC = 0, inp_ready = 0, oup_valid = 0, oup_data = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, halted = 0.
REQ-020 Reset asserted mid-instruction or mid-handshake SHALL abandon the operation with no memory write.
REQ-021 Fetch of ROM word 0 SHALL begin on the first rising edge after rst_n deasserts.

Configuration
REQ-022 Feature macro SUBLEQ_HALT_EN.
REQ-023 With SUBLEQ_HALT_EN defined, opcode 111 SHALL enter HALT with halted = 1, PC frozen and no memory strobes until reset, and opcodes 011/101/110 SHALL execute as SUBLEQ.
REQ-024 With SUBLEQ_HALT_EN undefined, all of 011/101/110/111 SHALL execute as SUBLEQ, the HALT state SHALL be absent, and halted SHALL be tied to 0.

Verification
REQ-025 SUBLEQ 5 6 9 at PC 0, with mem[5]=3 and mem[6]=7 -> mem[5]=0xFC, PC=9 after 4 cycles, one mem_we pulse.
REQ-026 SUBLEQ 5 6 9, with mem[5]=7 and mem[6]=3 -> mem[5]=0x04, PC=1.
REQ-027 IMM A=0 B=0x82, with mem[0]=0 -> mem[0]=0x7E, PC=1, instruction takes 3 cycles, mem_re never asserted with mem_addr=B.
REQ-028 EXR 4 0 2, with inp_valid raised 3 cycles after inp_ready and inp_data=0x5A -> inp_ready high for 4 cycles, mem[4]=0x5A, PC=2.
REQ-029 EXW 4 0 3, with mem[4]=0x5A and oup_ready low for 5 cycles then high -> oup_valid high for 6 cycles with oup_data=0x5A stable, PC=3.
REQ-030 rst_n pulsed low during OUTWAIT -> oup_valid=0 immediately and PC=0; separately, with SUBLEQ_HALT_EN, opcode 111 -> halted=1 and rom_addr constant for 20 cycles.
